// File: rtl/clint.sv
// rtl/clint.sv - core-local interrupt controller: mtime/mtimecmp timer and msip on a request/response bus
module clint #(
  parameter int XLEN     = 32,
  parameter int TICK_DIV = 1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            bus_req,
  input  logic            bus_write,
  input  logic [15:0]     bus_addr,
  input  logic [XLEN-1:0] bus_wdata,
  input  logic [3:0]      bus_wstrb,
  output logic            bus_ready,
  output logic            bus_rvalid,
  output logic [XLEN-1:0] bus_rdata,
  output logic            bus_err,
  input  logic            mtime_stop,
  output logic            software_interrupt,
  output logic            timer_interrupt,
  output logic [63:0]     mtime
);

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  logic        r_ready;
  logic        r_rvalid;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_msip;
  logic        r_tint;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [15:0] r_presc;

  logic        w_accept;
  logic        w_wr;
  logic        w_aligned;
  logic        w_sel_msip;
  logic        w_sel_cmp_lo;
  logic        w_sel_cmp_hi;
  logic        w_sel_mt_lo;
  logic        w_sel_mt_hi;
  logic        w_hit;
  logic        w_tick;
  logic        w_msip_next;
  logic [63:0] w_mtime_next;
  logic [63:0] w_cmp_next;
  logic [31:0] w_rd;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction

  assign w_accept     = bus_req & r_ready;
  assign w_wr         = w_accept & bus_write;
  assign w_aligned    = (bus_addr[1:0] == 2'b00);
  assign w_sel_msip   = (bus_addr == 16'h0000);
  assign w_sel_cmp_lo = (bus_addr == 16'h4000);
  assign w_sel_cmp_hi = (bus_addr == 16'h4004);
  assign w_sel_mt_lo  = (bus_addr == 16'hBFF8);
  assign w_sel_mt_hi  = (bus_addr == 16'hBFFC);
  assign w_hit        = w_aligned & (w_sel_msip | w_sel_cmp_lo | w_sel_cmp_hi |
                                     w_sel_mt_lo | w_sel_mt_hi);

  // With TICK_DIV = 1 the prescaler sits at 0 and every running cycle ticks.
  assign w_tick = ~mtime_stop & (r_presc == DIV_LAST);

  always_comb begin
    w_mtime_next = r_mtime;
    w_cmp_next   = r_mtimecmp;
    w_msip_next  = r_msip;
    // A write to either mtime word replaces the increment for that cycle.
    if (w_wr && w_sel_mt_lo) begin
      w_mtime_next[31:0] = merge_bytes(r_mtime[31:0], bus_wdata[31:0], bus_wstrb);
    end else if (w_wr && w_sel_mt_hi) begin
      w_mtime_next[63:32] = merge_bytes(r_mtime[63:32], bus_wdata[31:0], bus_wstrb);
    end else if (w_tick) begin
      w_mtime_next = r_mtime + 64'd1;
    end
    if (w_wr && w_sel_cmp_lo) begin
      w_cmp_next[31:0] = merge_bytes(r_mtimecmp[31:0], bus_wdata[31:0], bus_wstrb);
    end
    if (w_wr && w_sel_cmp_hi) begin
      w_cmp_next[63:32] = merge_bytes(r_mtimecmp[63:32], bus_wdata[31:0], bus_wstrb);
    end
    if (w_wr && w_sel_msip && bus_wstrb[0]) begin
      w_msip_next = bus_wdata[0];
    end
  end

  always_comb begin
    w_rd = 32'h0;
    if (w_hit) begin
      if (w_sel_msip)   w_rd = {31'h0, r_msip};
      if (w_sel_cmp_lo) w_rd = r_mtimecmp[31:0];
      if (w_sel_cmp_hi) w_rd = r_mtimecmp[63:32];
      if (w_sel_mt_lo)  w_rd = r_mtime[31:0];
      if (w_sel_mt_hi)  w_rd = r_mtime[63:32];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ready    <= 1'b0;
      r_rvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= 32'h0;
      r_msip     <= 1'b0;
      r_tint     <= 1'b0;
      r_mtime    <= 64'h0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_presc    <= 16'h0;
    end else begin
      r_ready    <= 1'b1;
      r_rvalid   <= w_accept;
      r_err      <= w_accept & ~w_hit;
      r_rdata    <= (w_accept && !bus_write) ? w_rd : 32'h0;
      r_msip     <= w_msip_next;
      r_tint     <= (w_mtime_next >= w_cmp_next);
      r_mtime    <= w_mtime_next;
      r_mtimecmp <= w_cmp_next;
      if (!mtime_stop) begin
        r_presc <= w_tick ? 16'h0 : r_presc + 16'h1;
      end
    end
  end

  assign bus_ready          = r_ready;
  assign bus_rvalid         = r_rvalid;
  assign bus_rdata          = XLEN'(r_rdata);
  assign bus_err            = r_err;
  assign software_interrupt = r_msip;
  assign timer_interrupt    = r_tint;
  assign mtime              = r_mtime;

endmodule

// File: tb/tb_clint.sv
// tb/tb_clint.sv - directed self-checking bench for clint
module tb_clint;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        bus_req;
  logic        bus_write;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        mtime_stop;

  logic        bus_ready, bus_rvalid, bus_err, software_interrupt, timer_interrupt;
  logic [31:0] bus_rdata;
  logic [63:0] mtime;

  logic        d4_ready, d4_rvalid, d4_err, d4_sw, d4_tint;
  logic [31:0] d4_rdata;
  logic [63:0] d4_mtime;

  int n_pass  = 0;
  int n_total = 0;

  logic        rv, er, prev_tint;
  logic [31:0] rd;

  always #5 clk = ~clk;

  clint #(.XLEN(32), .TICK_DIV(1)) u_dut (
    .clk(clk), .rst_b(rst_b), .bus_req(bus_req), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_err(bus_err), .mtime_stop(mtime_stop),
    .software_interrupt(software_interrupt), .timer_interrupt(timer_interrupt),
    .mtime(mtime)
  );

  clint #(.XLEN(32), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst_b(rst_b), .bus_req(bus_req), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(d4_ready), .bus_rvalid(d4_rvalid), .bus_rdata(d4_rdata),
    .bus_err(d4_err), .mtime_stop(mtime_stop),
    .software_interrupt(d4_sw), .timer_interrupt(d4_tint),
    .mtime(d4_mtime)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drives one request at posedge+1 and samples the response one edge later.
  task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic o_rv, output logic [31:0] o_rd,
                      output logic o_er);
    bus_req   = 1'b1;
    bus_write = wr;
    bus_addr  = a;
    bus_wdata = d;
    bus_wstrb = s;
    @(posedge clk);
    #1;
    bus_req   = 1'b0;
    bus_write = 1'b0;
    o_rv = bus_rvalid;
    o_rd = bus_rdata;
    o_er = bus_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_b = 1'b0; bus_req = 1'b0; bus_write = 1'b0; bus_addr = 16'h0;
    bus_wdata = 32'h0; bus_wstrb = 4'h0; mtime_stop = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus_ready, 0);
    chk("rst_rvalid", bus_rvalid, 0);
    chk("rst_tint", timer_interrupt, 0);
    chk("rst_sw", software_interrupt, 0);
    chk("rst_mtime", mtime, 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", bus_ready, 1);

    // Reset value of mtimecmp
    xfer(1'b0, 16'h4000, 32'h0, 4'h0, rv, rd, er);
    chk("cmp_lo_rvalid", rv, 1);
    chk("cmp_lo_rdata", rd, 32'hFFFF_FFFF);
    chk("cmp_lo_err", er, 0);
    xfer(1'b0, 16'h4004, 32'h0, 4'h0, rv, rd, er);
    chk("cmp_hi_rdata", rd, 32'hFFFF_FFFF);
    chk("cmp_hi_err", er, 0);
    chk("tint_idle", timer_interrupt, 0);

    // Prescaler divide-by-4, then freeze
    mtime_stop = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    mtime_stop = 1'b1;
    chk("div4_mtime", d4_mtime, 64'd10);
    repeat (20) @(posedge clk);
    #1;
    chk("div4_frozen", d4_mtime, 64'd10);

    // Timer compare
    xfer(1'b1, 16'h4004, 32'h0, 4'hF, rv, rd, er);
    xfer(1'b1, 16'hBFF8, 32'h0, 4'hF, rv, rd, er);
    xfer(1'b1, 16'h4000, 32'h20, 4'hF, rv, rd, er);
    chk("mtime_cleared", mtime, 0);
    chk("tint_below", timer_interrupt, 0);
    prev_tint  = 1'b1;
    mtime_stop = 1'b0;
    for (int i = 0; i < 64 && mtime !== 64'h20; i++) begin
      prev_tint = timer_interrupt;
      @(posedge clk);
      #1;
    end
    chk("mtime_reach_20", mtime, 64'h20);
    chk("tint_at_20", timer_interrupt, 1);
    chk("tint_at_1f", prev_tint, 0);
    xfer(1'b1, 16'h4000, 32'h100, 4'hF, rv, rd, er);
    mtime_stop = 1'b1;
    chk("tint_cmp_raised", timer_interrupt, 0);

    // Software interrupt
    xfer(1'b1, 16'h0000, 32'h1, 4'hF, rv, rd, er);
    chk("sw_set", software_interrupt, 1);
    chk("wr_rvalid", rv, 1);
    chk("wr_rdata_zero", rd, 0);
    xfer(1'b0, 16'h0000, 32'h0, 4'h0, rv, rd, er);
    chk("msip_read_1", rd, 32'h1);
    xfer(1'b1, 16'h0000, 32'hFFFF_FFFE, 4'hF, rv, rd, er);
    chk("sw_clr", software_interrupt, 0);
    xfer(1'b0, 16'h0000, 32'h0, 4'h0, rv, rd, er);
    chk("msip_read_0", rd, 32'h0);

    // 64-bit wrap
    xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, rv, rd, er);
    xfer(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, rv, rd, er);
    chk("mtime_near_wrap", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("tint_near_wrap", timer_interrupt, 1);
    xfer(1'b0, 16'hBFFC, 32'h0, 4'h0, rv, rd, er);
    chk("mtime_hi_read", rd, 32'hFFFF_FFFF);
    mtime_stop = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    mtime_stop = 1'b1;
    chk("mtime_wrapped", mtime, 64'h0);
    chk("tint_after_wrap", timer_interrupt, 0);

    // Byte write coinciding with a tick
    xfer(1'b1, 16'hBFF8, 32'h1234_5678, 4'hF, rv, rd, er);
    mtime_stop = 1'b0;
    xfer(1'b1, 16'hBFF8, 32'h0000_0005, 4'b0001, rv, rd, er);
    mtime_stop = 1'b1;
    chk("byte_wr_no_inc", mtime, 64'h0000_0000_1234_5605);

    // Error accesses
    xfer(1'b0, 16'h0100, 32'h0, 4'h0, rv, rd, er);
    chk("unmapped_rvalid", rv, 1);
    chk("unmapped_err", er, 1);
    chk("unmapped_rdata", rd, 0);
    xfer(1'b1, 16'h4002, 32'hDEAD_BEEF, 4'hF, rv, rd, er);
    chk("misalign_err", er, 1);
    xfer(1'b0, 16'h4000, 32'h0, 4'h0, rv, rd, er);
    chk("cmp_unchanged", rd, 32'h100);
    chk("good_err", er, 0);
    @(posedge clk);
    #1;
    chk("idle_rvalid", bus_rvalid, 0);
    chk("idle_rdata", bus_rdata, 0);

    // Reset mid-operation with a response in flight
    xfer(1'b1, 16'h0000, 32'h1, 4'h1, rv, rd, er);
    mtime_stop = 1'b0;
    bus_req = 1'b1; bus_write = 1'b0; bus_addr = 16'h4000;
    @(posedge clk);
    #1;
    bus_req = 1'b0;
    chk("inflight_rvalid", bus_rvalid, 1);
    chk("pre_rst_tint", timer_interrupt, 1);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_rvalid", bus_rvalid, 0);
    chk("mid_rst_rdata", bus_rdata, 0);
    chk("mid_rst_ready", bus_ready, 0);
    chk("mid_rst_sw", software_interrupt, 0);
    chk("mid_rst_tint", timer_interrupt, 0);
    chk("mid_rst_mtime", mtime, 0);
    chk("mid_rst_d4_mtime", d4_mtime, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
